// File: rtl/miim_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : miim_arbiter
// Brief    : Round-robin arbiter sharing one MIIM management master between
//            NUM_REQ requesters, one transaction in flight, with watchdog.
//            Optional `MIIM_ARB_LOCK_EN adds req_lock for atomic RMW ownership.
// Revision : 1.0 - initial release
// ============================================================================
module miim_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ-1:0]      req_write,
    input  logic [5*NUM_REQ-1:0]    req_phyad,
    input  logic [5*NUM_REQ-1:0]    req_regad,
    input  logic [16*NUM_REQ-1:0]   req_wrdata,
`ifdef MIIM_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]      req_lock,
`endif
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [15:0]             rsp_rddata,
    output logic                    rsp_err,
    output logic                    arb_busy,
    output logic [4:0]              miim_phyad,
    output logic [4:0]              miim_regad,
    output logic [15:0]             miim_wrdata,
    output logic                    miim_wren,
    output logic                    miim_rden,
    input  logic                    miim_busy,
    input  logic [15:0]             miim_rddata,
    input  logic                    miim_rddata_valid
);

    localparam int              c_IW      = $clog2(NUM_REQ);
    localparam logic [c_IW-1:0] c_LAST    = c_IW'(NUM_REQ - 1);
    localparam logic [15:0]     c_WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT     = 2'd2,
        S_COMPLETE = 2'd3
    } state_t;

    state_t          r_state, w_next;
    logic [c_IW-1:0] r_rr, r_owner;
    logic            r_write, r_busy_seen, r_data_seen, r_err;
    logic [4:0]      r_phyad, r_regad;
    logic [15:0]     r_wrdata, r_rddata, r_wd;

    logic [c_IW-1:0] w_scan_base, w_scan_idx, w_pick;
    logic            w_found, w_grant, w_done, w_timeout;
    logic            w_lock_hold, w_lock_release;
    logic [15:0]     w_wd_inc;

    logic [4:0]      w_phyad_arr  [NUM_REQ];
    logic [4:0]      w_regad_arr  [NUM_REQ];
    logic [15:0]     w_wrdata_arr [NUM_REQ];

    function automatic logic [c_IW-1:0] f_inc(input logic [c_IW-1:0] i);
        return (i == c_LAST) ? '0 : i + 1'b1;
    endfunction

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_phyad_arr[gi]  = req_phyad[5*gi +: 5];
        assign w_regad_arr[gi]  = req_regad[5*gi +: 5];
        assign w_wrdata_arr[gi] = req_wrdata[16*gi +: 16];
    end

`ifdef MIIM_ARB_LOCK_EN
    logic r_locked;
    assign w_lock_hold    = r_locked &  req_lock[r_owner];
    assign w_lock_release = r_locked & ~req_lock[r_owner];
`else
    assign w_lock_hold    = 1'b0;
    assign w_lock_release = 1'b0;
`endif

    // A released lock restarts the scan just past the previous owner.
    assign w_scan_base = w_lock_release ? f_inc(r_owner) : r_rr;
    assign w_grant     = w_found & ~miim_busy;
    assign w_wd_inc    = r_wd + 16'd1;
    // Watchdog starts at 0 in the first WAIT cycle, so the abort lands on
    // COMPLETE exactly TIMEOUT_CYCLES cycles after ISSUE.
    assign w_timeout   = (w_wd_inc == c_WD_LAST);
    assign w_done      = r_busy_seen & ~miim_busy &
                         (r_write | r_data_seen | miim_rddata_valid);

    assign arb_busy    = (r_state != S_IDLE);
    assign miim_phyad  = r_phyad;
    assign miim_regad  = r_regad;
    assign miim_wrdata = r_wrdata;

    always_comb begin
        w_found    = 1'b0;
        w_pick     = r_owner;
        w_scan_idx = w_scan_base;
        if (w_lock_hold) begin
            w_found = req_valid[r_owner];
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!w_found && req_valid[w_scan_idx]) begin
                    w_found = 1'b1;
                    w_pick  = w_scan_idx;
                end
                w_scan_idx = f_inc(w_scan_idx);
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = '0;
        rsp_valid  = '0;
        rsp_rddata = '0;
        rsp_err    = 1'b0;
        miim_wren  = 1'b0;
        miim_rden  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                req_ready[r_owner] = 1'b1;
                miim_wren          = r_write;
                miim_rden          = ~r_write;
                w_next             = S_WAIT;
            end
            S_WAIT: begin
                if (w_done || w_timeout) w_next = S_COMPLETE;
            end
            S_COMPLETE: begin
                rsp_valid[r_owner] = 1'b1;
                rsp_err            = r_err;
                rsp_rddata         = (!r_err && !r_write) ? r_rddata : 16'd0;
                w_next             = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rr        <= '0;
            r_owner     <= '0;
            r_write     <= 1'b0;
            r_phyad     <= '0;
            r_regad     <= '0;
            r_wrdata    <= '0;
            r_busy_seen <= 1'b0;
            r_data_seen <= 1'b0;
            r_rddata    <= '0;
            r_err       <= 1'b0;
            r_wd        <= '0;
`ifdef MIIM_ARB_LOCK_EN
            r_locked    <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
`ifdef MIIM_ARB_LOCK_EN
                    if (w_lock_release) begin
                        r_locked <= 1'b0;
                        r_rr     <= f_inc(r_owner);
                    end
`endif
                    if (w_grant) begin
                        r_owner  <= w_pick;
                        r_write  <= req_write[w_pick];
                        r_phyad  <= w_phyad_arr[w_pick];
                        r_regad  <= w_regad_arr[w_pick];
                        r_wrdata <= w_wrdata_arr[w_pick];
                    end
                end
                S_ISSUE: begin
                    r_busy_seen <= 1'b0;
                    r_err       <= 1'b0;
                    r_wd        <= '0;
                    // Read data may already arrive in the strobe cycle.
                    r_data_seen <= ~r_write & miim_rddata_valid;
                    r_rddata    <= (~r_write & miim_rddata_valid) ? miim_rddata : 16'd0;
                end
                S_WAIT: begin
                    r_wd <= w_wd_inc;
                    if (miim_busy) r_busy_seen <= 1'b1;
                    if (!r_write && !r_data_seen && miim_rddata_valid) begin
                        r_data_seen <= 1'b1;
                        r_rddata    <= miim_rddata;
                    end
                    if (!w_done && w_timeout) r_err <= 1'b1;
                end
                S_COMPLETE: begin
`ifdef MIIM_ARB_LOCK_EN
                    if (req_lock[r_owner]) r_locked <= 1'b1;
                    else                   r_rr     <= f_inc(r_owner);
`else
                    r_rr <= f_inc(r_owner);
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_miim_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_miim_arbiter
// Brief    : Directed self-checking bench for miim_arbiter (NUM_REQ=2,
//            TIMEOUT_CYCLES=100) with a behavioural MIIM master model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_miim_arbiter;

    localparam int c_N  = 2;
    localparam int c_TO = 100;

    logic             clk;
    logic             reset;
    logic [c_N-1:0]   req_valid, req_write;
    logic [5*c_N-1:0] req_phyad, req_regad;
    logic [16*c_N-1:0] req_wrdata;
`ifdef MIIM_ARB_LOCK_EN
    logic [c_N-1:0]   req_lock;
`endif
    logic [c_N-1:0]   req_ready, rsp_valid;
    logic [15:0]      rsp_rddata;
    logic             rsp_err, arb_busy;
    logic [4:0]       miim_phyad, miim_regad;
    logic [15:0]      miim_wrdata;
    logic             miim_wren, miim_rden;
    logic             miim_busy;
    logic [15:0]      miim_rddata;
    logic             miim_rddata_valid;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    // MIIM master model controls
    logic        m_busy, m_rd, m_hang, force_busy;
    int          m_cnt, busy_len;
    logic [15:0] model_data;
    logic        outstanding;

    assign miim_busy = m_busy | force_busy;

    miim_arbiter #(.NUM_REQ(c_N), .TIMEOUT_CYCLES(c_TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write),
        .req_phyad(req_phyad), .req_regad(req_regad), .req_wrdata(req_wrdata),
`ifdef MIIM_ARB_LOCK_EN
        .req_lock(req_lock),
`endif
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rddata(rsp_rddata), .rsp_err(rsp_err), .arb_busy(arb_busy),
        .miim_phyad(miim_phyad), .miim_regad(miim_regad), .miim_wrdata(miim_wrdata),
        .miim_wren(miim_wren), .miim_rden(miim_rden),
        .miim_busy(miim_busy), .miim_rddata(miim_rddata),
        .miim_rddata_valid(miim_rddata_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Busy rises the cycle after a strobe, stays up busy_len cycles; read data
    // is strobed in the first cycle busy is low again.
    always @(posedge clk) begin
        miim_rddata_valid <= 1'b0;
        if (reset) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_rd   <= 1'b0;
        end else if ((miim_wren || miim_rden) && !m_hang) begin
            m_busy <= 1'b1;
            m_cnt  <= busy_len;
            m_rd   <= miim_rden;
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                m_busy <= 1'b0;
                if (m_rd) begin
                    miim_rddata_valid <= 1'b1;
                    miim_rddata       <= model_data;
                end
            end
            m_cnt <= m_cnt - 1;
        end
    end

    // Global protocol watch: one strobe per completed transaction, ack with strobe.
    always @(negedge clk) begin
        if (reset) begin
            outstanding <= 1'b0;
        end else begin
            if (miim_wren || miim_rden) begin
                chk("one_in_flight", 32'(outstanding), 0);
                chk("ready_with_strobe", 32'($countones(req_ready)), 1);
                outstanding <= 1'b1;
            end
            if (rsp_valid != 0) outstanding <= 1'b0;
        end
    end

    task automatic set_req(input int i, input logic wr, input logic [4:0] pa,
                           input logic [4:0] ra, input logic [15:0] wd);
        req_write[i]          = wr;
        req_phyad[5*i +: 5]   = pa;
        req_regad[5*i +: 5]   = ra;
        req_wrdata[16*i +: 16] = wd;
    endtask

    task automatic wait_issue(output int idx, output int t);
        int n = 0;
        @(negedge clk);
        while (req_ready == 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("issue_seen", 32'(req_ready != 0), 1);
        idx = req_ready[1] ? 1 : 0;
        t   = cyc;
    endtask

    task automatic wait_rsp(output int t);
        int n = 0;
        @(negedge clk);
        while (rsp_valid == 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_seen", 32'(rsp_valid != 0), 1);
        t = cyc;
    endtask

    initial begin
        int idx, ti, tr, seen;
        reset = 1'b1; req_valid = '0; req_write = '0; req_phyad = '0;
        req_regad = '0; req_wrdata = '0; force_busy = 1'b0; m_hang = 1'b0;
        busy_len = 60; model_data = 16'h0; miim_rddata = 16'h0;
`ifdef MIIM_ARB_LOCK_EN
        req_lock = '0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_ctl", 32'({req_ready, rsp_valid, rsp_err, arb_busy, miim_wren, miim_rden}), 0);
        chk("reset_addr", 32'({miim_phyad, miim_regad, miim_wrdata}), 0);
        reset = 1'b0;

        // 1: requester 0 write, 60-cycle busy
        set_req(0, 1'b1, 5'd1, 5'd0, 16'h3100);
        req_valid[0] = 1'b1;
        wait_issue(idx, ti);
        req_valid[0] = 1'b0;
        chk("t1_owner", idx, 0);
        chk("t1_strobes", 32'({miim_wren, miim_rden}), 32'b10);
        chk("t1_fields", 32'({miim_phyad, miim_regad, miim_wrdata}), {5'd1, 5'd0, 16'h3100});
        @(negedge clk);
        chk("t1_wren_pulse", 32'(miim_wren), 0);
        chk("t1_fields_hold", 32'({miim_phyad, miim_regad, miim_wrdata}), {5'd1, 5'd0, 16'h3100});
        wait_rsp(tr);
        chk("t1_latency", tr - ti, 62);
        chk("t1_rsp", 32'({rsp_valid, rsp_err, rsp_rddata}), {2'b01, 1'b0, 16'h0});
        @(negedge clk);
        chk("t1_rsp_clear", 32'({rsp_valid, rsp_err, arb_busy}), 0);

        // 2: requester 1 read returns 0x01E1
        busy_len = 20; model_data = 16'h01E1;
        set_req(1, 1'b0, 5'd1, 5'd4, 16'h0);
        req_valid[1] = 1'b1;
        wait_issue(idx, ti);
        req_valid[1] = 1'b0;
        chk("t2_owner", idx, 1);
        chk("t2_strobes", 32'({miim_wren, miim_rden}), 32'b01);
        chk("t2_addr", 32'({miim_phyad, miim_regad}), {5'd1, 5'd4});
        wait_rsp(tr);
        chk("t2_latency", tr - ti, 22);
        chk("t2_rsp", 32'({rsp_valid, rsp_err, rsp_rddata}), {2'b10, 1'b0, 16'h01E1});
        @(negedge clk);
        chk("t2_rddata_clear", 32'(rsp_rddata), 0);

        // 3: both held valid from reset -> 0,1,0,1 with back-to-back gap of 2
        reset = 1'b1; busy_len = 5; model_data = 16'hBEEF;
        set_req(0, 1'b1, 5'd2, 5'd3, 16'h1234);
        set_req(1, 1'b0, 5'd4, 5'd5, 16'h0);
        req_valid = 2'b11;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        tr = 0;
        for (int k = 0; k < 4; k++) begin
            wait_issue(idx, ti);
            chk("t3_order", idx, k % 2);
            if (k > 0) chk("t3_gap", ti - tr, 2);
            wait_rsp(tr);
            chk("t3_rsp_owner", 32'(rsp_valid), 32'(1 << idx));
            chk("t3_rddata", 32'(rsp_rddata), (idx == 1) ? 32'hBEEF : 32'h0);
        end
        req_valid = '0;
        repeat (3) @(negedge clk);

        // 4: hung MIIM master -> timeout exactly TIMEOUT_CYCLES after ISSUE
        m_hang = 1'b1;
        set_req(0, 1'b0, 5'd3, 5'd1, 16'h0);
        req_valid[0] = 1'b1;
        wait_issue(idx, ti);
        req_valid[0] = 1'b0;
        chk("t4_owner", idx, 0);
        wait_rsp(tr);
        chk("t4_latency", tr - ti, c_TO);
        chk("t4_rsp", 32'({rsp_valid, rsp_err, rsp_rddata}), {2'b01, 1'b1, 16'h0});
        @(negedge clk);
        chk("t4_err_clear", 32'(rsp_err), 0);
        m_hang = 1'b0; busy_len = 8;
        set_req(1, 1'b1, 5'd7, 5'd9, 16'hA5A5);
        req_valid[1] = 1'b1;
        wait_issue(idx, ti);
        req_valid[1] = 1'b0;
        chk("t4_next_owner", idx, 1);
        chk("t4_next_fields", 32'({miim_wren, miim_phyad, miim_regad, miim_wrdata}),
            {1'b1, 5'd7, 5'd9, 16'hA5A5});
        wait_rsp(tr);
        chk("t4_next_latency", tr - ti, 10);
        chk("t4_next_rsp", 32'({rsp_valid, rsp_err}), {2'b10, 1'b0});

        // 5a: foreign MIIM access stalls the grant
        force_busy = 1'b1; model_data = 16'h5A5A;
        set_req(0, 1'b0, 5'd6, 5'd2, 16'h0);
        req_valid[0] = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (req_ready != 0 || miim_wren || miim_rden) seen = 1;
        end
        chk("t5_stall", seen, 0);
        force_busy = 1'b0;
        wait_issue(idx, ti);
        req_valid[0] = 1'b0;
        chk("t5_owner", idx, 0);
        wait_rsp(tr);
        chk("t5_rddata", 32'(rsp_rddata), 32'h5A5A);

        // 5b: reset during WAIT abandons the transaction
        busy_len = 40;
        set_req(1, 1'b0, 5'd8, 5'd1, 16'h0);
        req_valid[1] = 1'b1;
        wait_issue(idx, ti);
        req_valid[1] = 1'b0;
        chk("t5b_owner", idx, 1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t5b_reset_ctl", 32'({req_ready, rsp_valid, rsp_err, arb_busy, miim_wren, miim_rden}), 0);
        chk("t5b_reset_data", 32'({miim_phyad, miim_regad, miim_wrdata}), 0);
        chk("t5b_reset_rddata", 32'(rsp_rddata), 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid != 0 || miim_wren || miim_rden) seen = 1;
        end
        chk("t5b_no_rsp", seen, 0);
        busy_len = 4;
        set_req(0, 1'b1, 5'd9, 5'd9, 16'h0F0F);
        req_valid = 2'b11;
        wait_issue(idx, ti);
        req_valid[0] = 1'b0;
        chk("t5b_first_after_reset", idx, 0);
        wait_rsp(tr);
        wait_issue(idx, ti);
        req_valid[1] = 1'b0;
        chk("t5b_second", idx, 1);
        wait_rsp(tr);

`ifdef MIIM_ARB_LOCK_EN
        // 6: locked owner keeps the bus for a second transaction
        set_req(0, 1'b1, 5'd1, 5'd0, 16'h1111);
        set_req(1, 1'b1, 5'd2, 5'd0, 16'h2222);
        req_lock[0] = 1'b1;
        req_valid   = 2'b11;
        wait_issue(idx, ti);
        chk("t6_lock_1st", idx, 0);
        wait_rsp(tr);
        wait_issue(idx, ti);
        chk("t6_lock_2nd", idx, 0);
        req_lock[0] = 1'b0; req_valid[0] = 1'b0;
        wait_rsp(tr);
        wait_issue(idx, ti);
        req_valid[1] = 1'b0;
        chk("t6_lock_3rd", idx, 1);
        wait_rsp(tr);
        req_valid = 2'b11;
        wait_issue(idx, ti);
        req_valid[0] = 1'b0;
        chk("t6_nolock_1st", idx, 0);
        wait_rsp(tr);
        wait_issue(idx, ti);
        req_valid[1] = 1'b0;
        chk("t6_nolock_2nd", idx, 1);
        wait_rsp(tr);
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/miim_arbiter.md
Name: miim_arbiter

Overview:
Shares the single MIIM management master (mac_controller MIIM port) between NUM_REQ requesters, e.g. the phy_conf configurator and a link-status poller. Round-robin grant, one transaction in flight at a time. Per-requester accept/response handshake. Watchdog turns a hung transaction into an error response.

Parameters:
NUM_REQ, 2, number of requesters (2..4); index 0 is requester 0.
TIMEOUT_CYCLES, 65535, clk cycles from issue after which an unfinished transaction is aborted with error (16-bit counter; legal 16..65535).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  request pending per requester; fields below held stable until req_ready
req_write  in  NUM_REQ  1=write, 0=read
req_phyad  in  5*NUM_REQ  packed PHY address, requester i at [5i+4:5i]
req_regad  in  5*NUM_REQ  packed register address, same packing
req_wrdata  in  16*NUM_REQ  packed write data, requester i at [16i+15:16i]
req_ready  out  NUM_REQ  one-cycle accept pulse to granted requester
rsp_valid  out  NUM_REQ  one-cycle completion pulse to owning requester
rsp_rddata  out  16  read data, valid with rsp_valid; 0 for writes and errors
rsp_err  out  1  timeout flag, valid with rsp_valid
arb_busy  out  1  high from ISSUE through COMPLETE
miim_phyad  out  5  to MIIM master
miim_regad  out  5  to MIIM master
miim_wrdata  out  16  to MIIM master
miim_wren  out  1  one-cycle write strobe
miim_rden  out  1  one-cycle read strobe
miim_busy  in  1  MIIM master busy
miim_rddata  in  16  MIIM read data
miim_rddata_valid  in  1  MIIM read data strobe

Behaviour:
- Reset: all outputs 0, FSM IDLE, rr pointer 0, watchdog 0, flags cleared. Reset mid-transaction abandons it: no rsp_valid, no further strobes.
- FSM: IDLE -> ISSUE -> WAIT -> COMPLETE -> IDLE.
- IDLE: grant only when miim_busy=0 and any req_valid. Scan from rr pointer upward with wrap; first valid index wins. Latch owner, write, phyad, regad, wrdata into registers. Go to ISSUE next cycle.
- ISSUE, exactly 1 cycle:
  - miim_wren=write or miim_rden=!write.
  - miim_phyad/regad/wrdata driven from latched values; they hold those values until the next grant.
  - req_ready[owner]=1.
  - Clear busy_seen and data_seen, load watchdog with 0.
- WAIT:
  - Watchdog increments each cycle.
  - busy_seen set on first miim_busy=1.
  - For reads, miim_rddata_valid=1 captures miim_rddata and sets data_seen. Capture counts in any cycle from ISSUE onward; first capture wins.
  - Done when busy_seen=1 and miim_busy=0, and (write or data_seen).
  - If done and watchdog reaches TIMEOUT_CYCLES-1 in the same cycle, done wins.
  - Otherwise, watchdog reaching TIMEOUT_CYCLES-1 sets the error path.
- COMPLETE, 1 cycle:
  - rsp_valid[owner]=1.
  - rsp_err=1 on timeout, else 0.
  - rsp_rddata = captured data for a successful read, else 0.
  - rr pointer <= (owner+1) mod NUM_REQ.
  - Next cycle IDLE; a new grant is possible in that IDLE cycle (earliest ISSUE = COMPLETE+2).
- rsp_rddata/rsp_err return to 0 the cycle after COMPLETE.
- req_valid dropping before req_ready is a protocol violation; the arbiter takes no special action.
- miim_busy=1 in IDLE (foreign access): stall, no grant.
- Only one requester is ever acked per grant. Non-granted requesters see no req_ready and keep waiting.

Optional Feature:
MIIM_ARB_LOCK_EN: adds input req_lock [NUM_REQ].
- With it: if req_lock[owner]=1 in COMPLETE, the rr pointer is not advanced and ownership is retained. The next grant goes only to the owner while its req_lock stays 1, even if other req_valid are high, giving atomic read-modify-write. Lock is released when req_lock[owner]=0 is sampled in IDLE; the pointer then moves to owner+1 and normal arbitration resumes in the same cycle.
- Without it: the port is absent and arbitration is pure round-robin.

Test Plan:
1. req0 write, phyad=1, regad=0, wrdata=0x3100; MIIM model holds busy 60 cycles -> single-cycle miim_wren with 1/0/0x3100, req_ready[0] in the same cycle, rsp_valid[0] 1 cycle after busy falls, rsp_err=0, rsp_rddata=0.
2. req1 read, phyad=1, regad=4; model returns 0x01E1 with rddata_valid -> miim_rden pulse, rsp_valid[1] with rsp_rddata=0x01E1, rsp_err=0.
3. req0 and req1 held valid continuously from reset for 4 transactions -> grant order 0,1,0,1; never two strobes without intervening busy completion.
4. TIMEOUT_CYCLES=100, model never raises busy -> rsp_valid[owner] with rsp_err=1, rsp_rddata=0, exactly 100 cycles after ISSUE; arbiter then serves the next request normally.
5. miim_busy forced high while req0 valid -> no strobe and no req_ready until busy low. Separately, reset asserted in WAIT -> next cycle all outputs 0, no rsp_valid; post-reset request served by requester 0 first.
6. (MIIM_ARB_LOCK_EN) req0 lock held for 2 transactions while req1 valid -> order 0,0,1; with lock low, order 0,1.
